// File: rtl/periph_bus_slave_pkg.sv
// Shared constants for the peripheral bus responder: register word indices and
// the bit positions inside TCON and UCON.
package periph_bus_slave_pkg;

  // Word index taken from addr[5:2]
  localparam logic [3:0] REG_TH     = 4'd0;
  localparam logic [3:0] REG_TL     = 4'd1;
  localparam logic [3:0] REG_TCON   = 4'd2;
  localparam logic [3:0] REG_LED    = 4'd3;
  localparam logic [3:0] REG_SWITCH = 4'd4;
  localparam logic [3:0] REG_DIGI   = 4'd5;
  localparam logic [3:0] REG_TXD    = 4'd6;
  localparam logic [3:0] REG_RXD    = 4'd7;
  localparam logic [3:0] REG_UCON   = 4'd8;

  // TCON bits
  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  // UCON bits
  localparam int unsigned UCON_TX_IE   = 0;
  localparam int unsigned UCON_RX_IE   = 1;
  localparam int unsigned UCON_TX_DONE = 2;
  localparam int unsigned UCON_RX_FULL = 3;
  localparam int unsigned UCON_TX_BUSY = 4;
  localparam int unsigned UCON_RX_OVR  = 5;
  localparam int unsigned UCON_TX_OVR  = 6;

endpackage

// File: rtl/periph_timer.sv
// Free-running reload timer: TL counts up while enabled and reloads from TH on
// wrap; the wrap latches an interrupt status bit when interrupts are enabled.
module periph_timer
  import periph_bus_slave_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_th_i,
  input  logic        wr_tl_i,
  input  logic        wr_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;

  assign ovf = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  // Count/reload first, then let CPU writes override the same-cycle overflow effect
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_EN]) begin
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (ovf && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
    if (wr_th_i)   th_d   = wdata_i;
    if (wr_tl_i)   tl_d   = wdata_i;
    if (wr_tcon_i) tcon_d = wdata_i[2:0];
  end

  // Timer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;

endmodule

// File: rtl/periph_bus_slave.sv
// Memory-mapped peripheral responder: timer, LEDs, switches, 7-segment and UART
// byte buffers on the CPU data bus, plus the CPU interrupt request.
// Build option: define PERIPH_DIGI_EN to implement the 7-segment (DIGI) register.
module periph_bus_slave
  import periph_bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h4000_0000,
  parameter int unsigned LED_W = 8,
  parameter int unsigned SW_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch,
  output logic [11:0]       digi,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              irqout
);

  logic       sel;
  logic [3:0] idx;
  logic       rd_hit, wr_hit;

  logic [31:0] th, tl;
  logic [2:0]  tcon;

  logic [LED_W-1:0] led_q, led_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pending_q, pending_d;
  logic [7:0]       rxd_q, rxd_d;
  logic [6:0]       ucon_q, ucon_d;
  logic [6:0]       ucon_rd;
  logic             tx_busy_q;
  logic             irq_q, irq_d;

  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign sel    = (addr[31:6] == BASE[31:6]);
  assign idx    = addr[5:2];
  assign rd_hit = rd & sel;
  assign wr_hit = wr & sel;

  periph_timer u_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_th_i   (wr_hit && (idx == REG_TH)),
    .wr_tl_i   (wr_hit && (idx == REG_TL)),
    .wr_tcon_i (wr_hit && (idx == REG_TCON)),
    .wdata_i   (wdata),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon)
  );

  // Start is held only while a byte is pending and the core is idle; pending drops
  // on that edge, so the pulse is exactly one cycle and vanishes with reset.
  assign tx_start = pending_q & ~tx_busy;

  // Busy bit is live status, never stored
  always_comb begin
    ucon_rd               = ucon_q;
    ucon_rd[UCON_TX_BUSY] = pending_q | tx_busy;
  end

  // Next-state for LED, UART buffers and UCON; clears are applied before sets so
  // hardware events win over same-cycle read/W1C clears
  always_comb begin
    led_d                = led_q;
    tx_data_d            = tx_data_q;
    pending_d            = pending_q;
    rxd_d                = rxd_q;
    ucon_d               = ucon_q;
    ucon_d[UCON_TX_BUSY] = 1'b0;
    if (tx_start) pending_d = 1'b0;
    if (wr_hit) begin
      case (idx)
        REG_LED: led_d = wdata[LED_W-1:0];
        REG_TXD: begin
          if (pending_q) begin
            ucon_d[UCON_TX_OVR] = 1'b1;
          end else begin
            tx_data_d = wdata[7:0];
            pending_d = 1'b1;
          end
        end
        REG_UCON: begin
          ucon_d[UCON_TX_IE] = wdata[UCON_TX_IE];
          ucon_d[UCON_RX_IE] = wdata[UCON_RX_IE];
          if (wdata[UCON_RX_OVR]) ucon_d[UCON_RX_OVR] = 1'b0;
          if (wdata[UCON_TX_OVR]) ucon_d[UCON_TX_OVR] = 1'b0;
        end
        default: ;
      endcase
    end
    if (rd_hit && (idx == REG_UCON)) ucon_d[UCON_TX_DONE] = 1'b0;
    if (rd_hit && (idx == REG_RXD))  ucon_d[UCON_RX_FULL] = 1'b0;
    if (tx_busy_q && !tx_busy)       ucon_d[UCON_TX_DONE] = 1'b1;
    if (rx_valid) begin
      rxd_d                = rx_data;
      ucon_d[UCON_RX_FULL] = 1'b1;
      if (ucon_q[UCON_RX_FULL]) ucon_d[UCON_RX_OVR] = 1'b1;
    end
  end

  // Interrupt is computed from current state and registered, so it lags by one cycle
  always_comb begin
    irq_d = tcon[TCON_IS]
          | (ucon_q[UCON_TX_IE] & ucon_q[UCON_TX_DONE])
          | (ucon_q[UCON_RX_IE] & ucon_q[UCON_RX_FULL]);
  end

  // Peripheral state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      tx_data_q <= '0;
      pending_q <= 1'b0;
      rxd_q     <= '0;
      ucon_q    <= '0;
      tx_busy_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      tx_data_q <= tx_data_d;
      pending_q <= pending_d;
      rxd_q     <= rxd_d;
      ucon_q    <= ucon_d;
      tx_busy_q <= tx_busy;
      irq_q     <= irq_d;
    end
  end

`ifdef PERIPH_DIGI_EN
  logic [11:0] digi_q;

  // 7-segment drive register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digi_q <= '0;
    end else if (wr_hit && (idx == REG_DIGI)) begin
      digi_q <= wdata[11:0];
    end
  end

  assign digi = digi_q;
`else
  assign digi = '0;
`endif

  // Combinational read mux, zero outside the window or when rd is low
  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (idx)
        REG_TH:     rdata = th;
        REG_TL:     rdata = tl;
        REG_TCON:   rdata = {29'd0, tcon};
        REG_LED:    rdata = {{(32 - LED_W){1'b0}}, led_q};
        REG_SWITCH: rdata = {{(32 - SW_W){1'b0}}, switch};
`ifdef PERIPH_DIGI_EN
        REG_DIGI:   rdata = {20'd0, digi_q};
`endif
        REG_TXD:    rdata = {24'd0, tx_data_q};
        REG_RXD:    rdata = {24'd0, rxd_q};
        REG_UCON:   rdata = {25'd0, ucon_rd};
        default:    rdata = '0;
      endcase
    end
  end

  assign led     = led_q;
  assign tx_data = tx_data_q;
  assign irqout  = irq_q;

endmodule

// File: tb/tb_periph_bus_slave.sv
// Scoreboard bench for periph_bus_slave: stimulus queues expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_periph_bus_slave;

  localparam logic [31:0] BASE_A = 32'h4000_0000;
  localparam int I_TH = 0, I_TL = 1, I_TCON = 2, I_LED = 3, I_SW = 4, I_DIGI = 5;
  localparam int I_TXD = 6, I_RXD = 7, I_UCON = 8;

  logic        clk, reset, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  led, switch;
  logic [11:0] digi;
  logic [7:0]  tx_data, rx_data;
  logic        tx_start, tx_busy, rx_valid, irqout;

  periph_bus_slave dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .led      (led),
    .switch   (switch),
    .digi     (digi),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irqout   (irqout)
  );

  typedef enum int {K_RDATA, K_IRQ, K_TXSTART, K_TXDATA, K_LED, K_DIGI} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_RDATA:   return rdata;
      K_IRQ:     return {31'd0, irqout};
      K_TXSTART: return {31'd0, tx_start};
      K_TXDATA:  return {24'd0, tx_data};
      K_LED:     return {24'd0, led};
      default:   return {20'd0, digi};
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle; late ones are failures
  always @(negedge clk) begin : mon
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = observe(sb[i].kind);
        n_cmp++;
        if (sb[i].cyc < cyc || act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input kind_e k, input logic [31:0] e, input int dly,
                           input string nm);
    exp_t x;
    x.cyc  = cyc + dly;
    x.kind = k;
    x.exp  = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rd       = 1'b0;
    wr       = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] d);
    addr  = BASE_A | (32'(idx) << 2);
    wdata = d;
    wr    = 1'b1;
    next_cycle();
  endtask

  task automatic rd_reg(input int idx, input logic [31:0] e, input string nm);
    addr = BASE_A | (32'(idx) << 2);
    rd   = 1'b1;
    expect_at(K_RDATA, e, 0, nm);
    next_cycle();
  endtask

  logic [31:0] digi_exp;

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    switch = 8'h00; tx_busy = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
`ifdef PERIPH_DIGI_EN
    digi_exp = 32'h0000_0ABC;
`else
    digi_exp = 32'h0;
`endif
    next_cycle();

    // Reset state
    expect_at(K_IRQ, 0, 0, "rst_irq");
    expect_at(K_TXSTART, 0, 0, "rst_txstart");
    expect_at(K_LED, 0, 0, "rst_led");
    expect_at(K_TXDATA, 0, 0, "rst_txdata");
    expect_at(K_DIGI, 0, 0, "rst_digi");
    rd_reg(I_TL, 32'h0, "rst_tl");
    rd_reg(I_UCON, 32'h0, "rst_ucon");
    reset = 1'b1;
    next_cycle();

    // Timer overflow with reload and irq status
    wr_reg(I_TH, 32'hFFFF_FFF0);
    wr_reg(I_TL, 32'hFFFF_FFFE);
    wr_reg(I_TCON, 32'h3);
    next_cycle();
    next_cycle();
    expect_at(K_IRQ, 0, 0, "tmr_irq_before");
    expect_at(K_IRQ, 1, 1, "tmr_irq_rise");
    rd_reg(I_TL, 32'hFFFF_FFF0, "tmr_tl_reload");
    rd_reg(I_TCON, 32'h7, "tmr_tcon_status");
    wr_reg(I_TCON, 32'h3);
    expect_at(K_IRQ, 1, 0, "tmr_irq_hold");
    expect_at(K_IRQ, 0, 1, "tmr_irq_drop");
    wr_reg(I_TCON, 32'h0);
    rd_reg(I_TH, 32'hFFFF_FFF0, "tmr_th");

    // UART TX: one start pulse, then a dropped write while still pending
    wr_reg(I_TXD, 32'h0000_005A);
    expect_at(K_TXSTART, 1, 0, "tx_start_pulse");
    expect_at(K_TXDATA, 32'h5A, 0, "tx_data");
    expect_at(K_TXSTART, 0, 1, "tx_start_end");
    wr_reg(I_TXD, 32'h0000_0033);
    expect_at(K_TXDATA, 32'h5A, 0, "tx_data_kept");
    rd_reg(I_UCON, 32'h40, "tx_overrun");
    wr_reg(I_UCON, 32'h41);
    rd_reg(I_UCON, 32'h01, "ucon_w1c");
    // tx done on falling busy, cleared by the UCON read
    tx_busy = 1'b1;
    next_cycle();
    tx_busy = 1'b0;
    next_cycle();
    expect_at(K_IRQ, 0, 0, "txdone_irq_pre");
    expect_at(K_IRQ, 1, 1, "txdone_irq");
    expect_at(K_IRQ, 0, 2, "txdone_irq_clr");
    rd_reg(I_UCON, 32'h05, "tx_done");
    wr_reg(I_UCON, 32'h0);

    // UART RX with rx irq
    wr_reg(I_UCON, 32'h2);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    next_cycle();
    expect_at(K_IRQ, 0, 0, "rx_irq_pre");
    expect_at(K_IRQ, 1, 1, "rx_irq");
    rd_reg(I_UCON, 32'h0A, "rx_full");
    rd_reg(I_RXD, 32'hA5, "rx_data");
    expect_at(K_IRQ, 1, 0, "rx_irq_hold");
    expect_at(K_IRQ, 0, 1, "rx_irq_drop");
    rd_reg(I_UCON, 32'h02, "rx_full_clr");

    // RX collision with RXD read
    rx_data  = 8'h11;
    rx_valid = 1'b1;
    next_cycle();
    rx_data  = 8'h22;
    rx_valid = 1'b1;
    rd_reg(I_RXD, 32'h11, "rxc_old");
    rd_reg(I_UCON, 32'h2A, "rxc_ucon");
    rd_reg(I_RXD, 32'h22, "rxc_new");
    rd_reg(I_UCON, 32'h22, "rxc_cleared");
    wr_reg(I_UCON, 32'h20);
    rd_reg(I_UCON, 32'h0, "rx_ovr_w1c");

    // Decode
    switch = 8'h81;
    rd_reg(I_SW, 32'h81, "dec_switch");
    rd_reg(12, 32'h0, "dec_unmapped");
    addr = 32'h0000_0010;
    rd   = 1'b1;
    expect_at(K_RDATA, 0, 0, "dec_outside");
    next_cycle();
    addr = BASE_A | 32'h10;
    expect_at(K_RDATA, 0, 0, "dec_rd_low");
    next_cycle();
    wr_reg(I_LED, 32'h0000_01C3);
    expect_at(K_LED, 32'hC3, 0, "led_out");
    rd_reg(I_LED, 32'hC3, "led_read");
    wr_reg(I_DIGI, 32'h0000_FABC);
    expect_at(K_DIGI, digi_exp, 0, "digi_out");
    rd_reg(I_DIGI, digi_exp, "digi_read");
    rd_reg(I_TXD, 32'h5A, "txd_read");

    // Reset while a byte is pending behind a busy TX core
    tx_busy = 1'b1;
    wr_reg(I_TXD, 32'h77);
    expect_at(K_TXDATA, 32'h77, 0, "pend_txdata");
    expect_at(K_TXSTART, 0, 0, "pend_held");
    next_cycle();
    addr    = BASE_A | (32'(I_TH) << 2);
    rd      = 1'b1;
    tx_busy = 1'b0;
    reset   = 1'b0;
    expect_at(K_RDATA, 0, 0, "arst_th");
    expect_at(K_TXSTART, 0, 0, "arst_txstart");
    expect_at(K_LED, 0, 0, "arst_led");
    expect_at(K_TXDATA, 0, 0, "arst_txdata");
    next_cycle();
    rd_reg(I_TL, 32'h0, "arst_tl");
    reset = 1'b1;
    next_cycle();
    expect_at(K_TXSTART, 0, 0, "post_rst_txstart");
    expect_at(K_IRQ, 0, 0, "post_rst_irq");
    rd_reg(I_UCON, 32'h0, "post_rst_ucon");
    rd_reg(I_TXD, 32'h0, "post_rst_txd");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb.size() != 0; i++) next_cycle();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
